// File: rtl/cache_refill.sv
// Cache line refill engine.
// Takes a miss request from the cache front-end and issues one AXI read burst
// for the whole line. Each returned beat is written into the data array of the
// victim way as it arrives. When the burst ends cleanly, the tag/valid entry is
// written and the replacer is told about the fill. Bad responses or a
// misplaced rlast still consume the full burst, but the line is not validated.
// Latency with zero-wait memory: accept cycle, one AR cycle, four beat cycles,
// then the FILL cycle with done (7 cycles counting the accept cycle).
module cache_refill #(
  parameter int NSET       = 8,
  parameter int NWAY       = 8,
  parameter int LINE_WORDS = 4,
  localparam int IDX_W     = $clog2(NSET),
  localparam int WAY_W     = $clog2(NWAY),
  localparam int BEAT_W    = $clog2(LINE_WORDS),
  localparam int OFF_W     = $clog2(LINE_WORDS * 4),
  localparam int TAG_W     = 32 - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,

  // miss request from the cache front-end
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [WAY_W-1:0]  victim_way,

  // fill notification to the replacer
  output logic              rep_access,
  output logic [IDX_W-1:0]  rep_idx,
  output logic [WAY_W-1:0]  rep_way,

  // AXI read-address channel
  output logic              arvalid,
  input  logic              arready,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,

  // AXI read-data channel
  input  logic              rvalid,
  output logic              rready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,

  // data-array write port
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [WAY_W-1:0]  wr_way,
  output logic [BEAT_W-1:0] wr_word,
  output logic [31:0]       wr_data,

  // tag/valid array write port (the valid bit is implied by the write)
  output logic              tag_we,
  output logic [IDX_W-1:0]  tag_idx,
  output logic [WAY_W-1:0]  tag_way,
  output logic [TAG_W-1:0]  tag_val,

  // completion
  output logic              done,
  output logic              done_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_R    = 2'd2;
  localparam logic [1:0] ST_FILL = 2'd3;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [7:0]        BURST_LEN = 8'(LINE_WORDS - 1);

  logic [1:0]        state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg,   idx_next;
  logic [TAG_W-1:0]  tag_reg,   tag_next;
  logic [WAY_W-1:0]  way_reg,   way_next;
  logic [BEAT_W-1:0] beat_reg,  beat_next;
  logic              err_reg,   err_next;

  logic in_idle;
  logic in_ar;
  logic in_r;
  logic in_fill;
  logic beat_fire;
  logic beat_is_last;
  logic beat_bad;

  // The byte offset within the line never matters: the burst always starts at
  // the line base.
  logic unused_offset_bits;
  assign unused_offset_bits = ^req_addr[OFF_W-1:0];

  assign in_idle = (state_reg == ST_IDLE);
  assign in_ar   = (state_reg == ST_AR);
  assign in_r    = (state_reg == ST_R);
  assign in_fill = (state_reg == ST_FILL);

  assign beat_fire    = in_r & rvalid;
  assign beat_is_last = (beat_reg == LAST_BEAT);
  // A beat is bad on an error response, or when rlast disagrees with the
  // beat count (early rlast, or missing rlast on the final beat).
  assign beat_bad     = (rresp != 2'b00) | (rlast != beat_is_last);

  // Next-state and latch logic; the burst length is fixed by the beat count,
  // so rlast only feeds the error flag and never ends the burst.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    tag_next   = tag_reg;
    way_next   = way_reg;
    beat_next  = beat_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          idx_next   = req_addr[OFF_W +: IDX_W];
          tag_next   = req_addr[31 -: TAG_W];
          way_next   = victim_way;
          beat_next  = '0;
          err_next   = 1'b0;
          state_next = ST_AR;
        end
      end
      ST_AR: begin
        if (arready) begin
          state_next = ST_R;
        end
      end
      ST_R: begin
        if (rvalid) begin
          beat_next = beat_reg + BEAT_W'(1);
          if (beat_bad) begin
            err_next = 1'b1;
          end
          if (beat_is_last) begin
            state_next = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and latched request; reset drops any burst in flight on the spot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      tag_reg   <= '0;
      way_reg   <= '0;
      beat_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      tag_reg   <= tag_next;
      way_reg   <= way_next;
      beat_reg  <= beat_next;
      err_reg   <= err_next;
    end
  end

  // Request side: only idle accepts a new miss.
  assign req_ready = in_idle;

  // Address channel: the line base is rebuilt from the latched tag and index
  // so it stays stable for as long as arready is held off.
  assign arvalid = in_ar;
  assign araddr  = in_ar ? {tag_reg, idx_reg, OFF_W'(0)} : 32'd0;
  assign arlen   = in_ar ? BURST_LEN : 8'd0;

  // Data channel and data-array write: each accepted beat is written in the
  // same cycle; payload is zeroed when no write is happening.
  assign rready  = in_r;
  assign wr_en   = beat_fire;
  assign wr_idx  = beat_fire ? idx_reg  : '0;
  assign wr_way  = beat_fire ? way_reg  : '0;
  assign wr_word = beat_fire ? beat_reg : '0;
  assign wr_data = beat_fire ? rdata    : 32'd0;

  // Fill cycle: validate the line and tell the replacer only on a clean burst.
  assign tag_we     = in_fill & ~err_reg;
  assign tag_idx    = tag_we ? idx_reg : '0;
  assign tag_way    = tag_we ? way_reg : '0;
  assign tag_val    = tag_we ? tag_reg : '0;
  assign rep_access = tag_we;
  assign rep_idx    = tag_we ? idx_reg : '0;
  assign rep_way    = tag_we ? way_reg : '0;

  assign done     = in_fill;
  assign done_err = in_fill & err_reg;

endmodule

// File: tb/tb_cache_refill.sv
// Bench for cache_refill: directed transactions against a transaction-level
// model (expected write list, error outcome, tag and latency per request),
// checked every cycle at the falling edge, plus literal expectations.
module tb_cache_refill;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [2:0]  victim_way;
  logic        rep_access;
  logic [2:0]  rep_idx, rep_way;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        wr_en;
  logic [2:0]  wr_idx, wr_way;
  logic [1:0]  wr_word;
  logic [31:0] wr_data;
  logic        tag_we;
  logic [2:0]  tag_idx, tag_way;
  logic [24:0] tag_val;
  logic        done, done_err;

  cache_refill dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .victim_way(victim_way),
    .rep_access(rep_access), .rep_idx(rep_idx), .rep_way(rep_way),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_way(wr_way), .wr_word(wr_word), .wr_data(wr_data),
    .tag_we(tag_we), .tag_idx(tag_idx), .tag_way(tag_way), .tag_val(tag_val),
    .done(done), .done_err(done_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]  idx;
    logic [2:0]  way;
    logic [1:0]  word;
    logic [31:0] data;
  } wr_t;

  // stimulus description of the current burst (written by the driver only)
  logic [31:0] cfg_dbase;
  logic [1:0]  cfg_resp [4];
  logic        cfg_last [4];
  int          cfg_latency;

  // model state and captures (written by the compare process only)
  wr_t         exp_q[$];
  logic        busy;
  logic        exp_err;
  logic [24:0] exp_tag;
  logic [2:0]  exp_idx, exp_way;
  logic [31:0] exp_araddr;
  int          cyc, acc_cyc, last_wr_cyc, acc_cnt, done_cnt, cap_nwr, cap_latency;
  logic        cap_done_err, cap_tag_we, cap_rep_access;
  logic [24:0] cap_tag_val;
  logic [2:0]  cap_tag_idx, cap_tag_way, cap_rep_idx, cap_rep_way;
  logic [31:0] cap_araddr, cap_last_data;
  logic [7:0]  cap_arlen;
  logic [1:0]  cap_last_word;

  // compare process
  initial begin
    wr_t e;
    busy = 1'b0; cyc = 0; acc_cyc = 0; last_wr_cyc = 0; acc_cnt = 0; done_cnt = 0;
    cap_nwr = 0; cap_latency = 0; exp_err = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_ctrl", 64'({arvalid, rready, wr_en, tag_we, rep_access, done, done_err}), 64'd0);
        chk("rst_ar", 64'({araddr, arlen}), 64'd0);
        chk("rst_wr", 64'({wr_idx, wr_way, wr_word, wr_data}), 64'd0);
        chk("rst_tag", 64'({tag_idx, tag_way, tag_val, rep_idx, rep_way}), 64'd0);
        exp_q.delete();
        busy = 1'b0;
      end else begin
        chk("req_ready", 64'(req_ready), 64'(!busy));
        if (!busy) begin
          chk("idle_quiet", 64'({arvalid, rready, wr_en, done, tag_we, rep_access}), 64'd0);
          if (req_valid && req_ready) begin
            busy = 1'b1; acc_cyc = cyc; acc_cnt++; cap_nwr = 0;
            exp_idx = req_addr[6:4];
            exp_tag = req_addr[31:7];
            exp_way = victim_way;
            exp_araddr = {req_addr[31:4], 4'h0};
            exp_err = 1'b0;
            exp_q.delete();
            for (int i = 0; i < 4; i++) begin
              e.idx = exp_idx; e.way = exp_way; e.word = 2'(i); e.data = cfg_dbase + 32'(i);
              exp_q.push_back(e);
              if (cfg_resp[i] != 2'b00) exp_err = 1'b1;
              if (cfg_last[i] != (i == 3)) exp_err = 1'b1;
            end
          end
        end else begin
          chk("ar_r_excl", 64'(arvalid & rready), 64'd0);
          chk("wr_en_beat", 64'(wr_en), 64'(rready & rvalid));
          chk("fill_strobes", 64'({tag_we, rep_access}), 64'({2{done & ~exp_err}}));
          if (arvalid) begin
            chk("araddr", 64'(araddr), 64'(exp_araddr));
            chk("arlen", 64'(arlen), 64'd3);
            cap_araddr = araddr; cap_arlen = arlen;
          end
          if (wr_en) begin
            if (exp_q.size() == 0) begin
              chk("extra_write", 64'(wr_en), 64'd0);
            end else begin
              e = exp_q.pop_front();
              chk("wr_beat", 64'({wr_idx, wr_way, wr_word, wr_data}), 64'(e));
            end
            cap_nwr++; last_wr_cyc = cyc; cap_last_data = wr_data; cap_last_word = wr_word;
          end
          if (done) begin
            chk("done_err", 64'(done_err), 64'(exp_err));
            if (!exp_err) begin
              chk("tag_val", 64'(tag_val), 64'(exp_tag));
              chk("tag_loc", 64'({tag_idx, tag_way}), 64'({exp_idx, exp_way}));
              chk("rep_loc", 64'({rep_idx, rep_way}), 64'({exp_idx, exp_way}));
            end
            chk("writes_left", 64'(exp_q.size()), 64'd0);
            chk("latency", 64'(cyc - acc_cyc), 64'(cfg_latency));
            chk("done_after_beat", 64'(cyc - last_wr_cyc), 64'd1);
            cap_latency = cyc - acc_cyc; cap_done_err = done_err; cap_tag_we = tag_we;
            cap_rep_access = rep_access; cap_tag_val = tag_val; cap_tag_idx = tag_idx;
            cap_tag_way = tag_way; cap_rep_idx = rep_idx; cap_rep_way = rep_way;
            done_cnt++;
            busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] dbase, input int err_beat,
                         input logic [3:0] last_mask, input int lat);
    cfg_dbase = dbase;
    for (int i = 0; i < 4; i++) begin
      cfg_resp[i] = (i == err_beat) ? 2'b10 : 2'b00;
      cfg_last[i] = last_mask[i];
    end
    cfg_latency = lat;
  endtask

  task automatic do_request(input logic [31:0] addr, input logic [2:0] way, input logic hold);
    logic got;
    got = 1'b0;
    req_valid = 1'b1; req_addr = addr; victim_way = way;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = req_ready;
      tick();
    end
    chk("accept_seen", 64'(got), 64'd1);
    if (hold) req_addr = ~addr;
    else req_valid = 1'b0;
  endtask

  task automatic do_ar(input int ard);
    arready = 1'b0;
    repeat (ard) tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic do_beat(input logic [31:0] data, input logic [1:0] resp, input logic last);
    logic ok;
    ok = 1'b0;
    rvalid = 1'b1; rdata = data; rresp = resp; rlast = last;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = rready;
      tick();
    end
    rvalid = 1'b0; rresp = 2'b00; rlast = 1'b0;
    chk("beat_taken", 64'(ok), 64'd1);
  endtask

  int txn_no = 0;

  task automatic run_txn(input logic [31:0] addr, input logic [2:0] way, input int ard,
                         input int gap, input logic [31:0] dbase, input int err_beat,
                         input logic [3:0] last_mask, input logic hold);
    int dn, ac;
    set_cfg(dbase, err_beat, last_mask, 6 + ard + 4 * gap);
    dn = done_cnt; ac = acc_cnt;
    do_request(addr, way, hold);
    do_ar(ard);
    for (int i = 0; i < 4; i++) begin
      repeat (gap) tick();
      do_beat(dbase + 32'(i), cfg_resp[i], cfg_last[i]);
    end
    for (int k = 0; k < 20 && done_cnt == dn; k++) tick();
    if (hold) req_valid = 1'b0;
    chk("done_once", 64'(done_cnt - dn), 64'd1);
    chk("accept_once", 64'(acc_cnt - ac), 64'd1);
    txn_no++;
    $display("txn %0d addr=%h way=%0d done_err=%0d latency=%0d writes=%0d",
             txn_no, addr, way, cap_done_err, cap_latency, cap_nwr);
  endtask

  task automatic run_abort();
    int dn;
    set_cfg(32'hC0, -1, 4'b1000, 6);
    dn = done_cnt;
    do_request(32'h0000_0030, 3'd4, 1'b0);
    do_ar(0);
    do_beat(32'hC0, 2'b00, 1'b0);
    do_beat(32'hC1, 2'b00, 1'b0);
    rvalid = 1'b1; rdata = 32'hC2; rresp = 2'b00; rlast = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    repeat (4) tick();
    rvalid = 1'b0;
    chk("abort_no_done", 64'(done_cnt - dn), 64'd0);
    chk("abort_writes", 64'(cap_nwr), 64'd2);
    txn_no++;
    $display("txn %0d addr=00000030 aborted by reset after %0d writes", txn_no, cap_nwr);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = 32'd0; victim_way = 3'd0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // nominal zero-wait fill
    run_txn(32'h8000_0154, 3'd5, 0, 0, 32'hA0, -1, 4'b1000, 1'b0);
    chk("nom_araddr", 64'(cap_araddr), 64'h8000_0150);
    chk("nom_arlen", 64'(cap_arlen), 64'd3);
    chk("nom_tag_val", 64'(cap_tag_val), 64'h100_0002);
    chk("nom_tag_loc", 64'({cap_tag_idx, cap_tag_way}), 64'({3'd5, 3'd5}));
    chk("nom_rep", 64'({cap_rep_access, cap_rep_idx, cap_rep_way}), 64'({1'b1, 3'd5, 3'd5}));
    chk("nom_done_err", 64'(cap_done_err), 64'd0);
    chk("nom_latency", 64'(cap_latency), 64'd6);
    chk("nom_last_beat", 64'({cap_last_word, cap_last_data}), 64'({2'd3, 32'hA3}));

    // backpressure on both channels
    run_txn(32'h1234_5678, 3'd2, 3, 2, 32'hB0, -1, 4'b1000, 1'b0);
    chk("bp_araddr", 64'(cap_araddr), 64'h1234_5670);
    chk("bp_latency", 64'(cap_latency), 64'd17);
    chk("bp_writes", 64'(cap_nwr), 64'd4);

    // error response on beat 1
    run_txn(32'h0000_0020, 3'd7, 0, 0, 32'hD0, 1, 4'b1000, 1'b0);
    chk("err_done_err", 64'(cap_done_err), 64'd1);
    chk("err_no_fill", 64'({cap_tag_we, cap_rep_access}), 64'd0);
    chk("err_writes", 64'(cap_nwr), 64'd4);

    // rlast already on beat 2
    run_txn(32'h4000_1040, 3'd0, 0, 1, 32'hE0, -1, 4'b1100, 1'b0);
    chk("early_last_err", 64'(cap_done_err), 64'd1);
    chk("early_last_writes", 64'(cap_nwr), 64'd4);

    // no rlast on beat 3
    run_txn(32'h4000_1040, 3'd6, 0, 0, 32'hE8, -1, 4'b0000, 1'b0);
    chk("no_last_err", 64'(cap_done_err), 64'd1);
    chk("no_last_writes", 64'(cap_nwr), 64'd4);

    // req_valid held (with a changing address) for the whole burst
    run_txn(32'hFFFF_FF80, 3'd1, 1, 0, 32'hF0, -1, 4'b1000, 1'b1);
    chk("hold_araddr", 64'(cap_araddr), 64'hFFFF_FF80);
    chk("hold_tag_val", 64'(cap_tag_val), 64'h1FF_FFFF);

    // reset during beat 2, then a normal fill afterwards
    run_abort();
    run_txn(32'h0000_00F0, 3'd3, 0, 0, 32'h11, -1, 4'b1000, 1'b0);
    chk("post_rst_tag", 64'({cap_tag_val, cap_tag_idx, cap_tag_way}), 64'({25'd1, 3'd7, 3'd3}));
    chk("post_rst_latency", 64'(cap_latency), 64'd6);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
